// File: rtl/second_operand_stage.sv
// ALU operand-B select (forwarded reg / immediates / PC / 4), registered behind valid/ready.
// One-cycle latency; a one-entry skid absorbs a single downstream stall, so in_ready is a flop output.
module second_operand_stage #(
    parameter int XLEN   = 32,
    parameter bit FWD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      Si,
    input  logic [31:0]     instr,
    input  logic [4:0]      rs2,
    input  logic [XLEN-1:0] PB,
    input  logic [XLEN-1:0] PC,
    input  logic            ex_wr,
    input  logic            mem_wr,
    input  logic            wb_wr,
    input  logic [4:0]      ex_rd,
    input  logic [4:0]      mem_rd,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] ex_val,
    input  logic [XLEN-1:0] mem_val,
    input  logic [XLEN-1:0] wb_val,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] N,
    output logic [1:0]      fwd_hit
);

    typedef struct packed {
        logic [1:0]      hit;
        logic [XLEN-1:0] val;
    } opnd_t;

    logic [XLEN-1:0] imm_i, imm_s, imm_u, imm_b, imm_j;
    logic            unused_instr;
    opnd_t           in_opnd;

    opnd_t out_q, out_d, skid_q, skid_d;
    logic  out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic  accept, load_out;

    // Opcode bits carry no immediate payload.
    assign unused_instr = ^instr[6:0];

    always_comb begin
        imm_i = XLEN'($signed(instr[31:20]));
        imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
        imm_u = XLEN'($signed({instr[31:12], 12'b0}));
        imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
        imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
    end

    always_comb begin
        in_opnd = '0;
        case (Si)
            3'b000: begin
                if (rs2 == 5'd0) begin
                    in_opnd = '0;
                end else if (FWD_EN && ex_wr && (ex_rd == rs2)) begin
                    in_opnd.val = ex_val;
                    in_opnd.hit = 2'd1;
                end else if (FWD_EN && mem_wr && (mem_rd == rs2)) begin
                    in_opnd.val = mem_val;
                    in_opnd.hit = 2'd2;
                end else if (FWD_EN && wb_wr && (wb_rd == rs2)) begin
                    in_opnd.val = wb_val;
                    in_opnd.hit = 2'd3;
                end else begin
                    in_opnd.val = PB;
                end
            end
            3'b001:  in_opnd.val = imm_i;
            3'b010:  in_opnd.val = imm_s;
            3'b011:  in_opnd.val = imm_u;
            3'b100:  in_opnd.val = PC;
            3'b101:  in_opnd.val = imm_b;
            3'b110:  in_opnd.val = imm_j;
            default: in_opnd.val = XLEN'(4);
        endcase
    end

    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && !skid_valid_q;
    assign load_out = !out_valid_q || out_ready;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            // Data registers keep their contents; only the valids are squashed.
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (load_out) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_d = in_opnd;
                end
            end
        end else if (accept) begin
            skid_d       = in_opnd;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign N         = out_q.val;
    assign fwd_hit   = out_q.hit;

endmodule

// File: tb/tb_second_operand_stage.sv
// Directed and randomized checks of second_operand_stage at XLEN=32 and XLEN=64.
module tb_second_operand_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, flush, in_valid, out_ready;
    logic [2:0]  Si;
    logic [31:0] instr;
    logic [4:0]  rs2, ex_rd, mem_rd, wb_rd;
    logic        ex_wr, mem_wr, wb_wr;
    logic [31:0] PB, PC, ex_val, mem_val, wb_val;
    logic        in_ready, out_valid;
    logic [31:0] N;
    logic [1:0]  fwd_hit;

    logic [63:0] PC64;
    wire  [63:0] PB64      = {32'h0, PB};
    wire  [63:0] ex_val64  = {32'h0, ex_val};
    wire  [63:0] mem_val64 = {32'h0, mem_val};
    wire  [63:0] wb_val64  = {32'h0, wb_val};
    logic        in_ready64, out_valid64;
    logic [63:0] N64;
    logic [1:0]  fwd_hit64;

    second_operand_stage #(.XLEN(32), .FWD_EN(1'b1)) dut32 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .Si(Si), .instr(instr), .rs2(rs2), .PB(PB), .PC(PC),
        .ex_wr(ex_wr), .mem_wr(mem_wr), .wb_wr(wb_wr),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_val(ex_val), .mem_val(mem_val), .wb_val(wb_val),
        .out_valid(out_valid), .out_ready(out_ready), .N(N), .fwd_hit(fwd_hit)
    );

    second_operand_stage #(.XLEN(64), .FWD_EN(1'b1)) dut64 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .Si(Si), .instr(instr), .rs2(rs2), .PB(PB64), .PC(PC64),
        .ex_wr(ex_wr), .mem_wr(mem_wr), .wb_wr(wb_wr),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_val(ex_val64), .mem_val(mem_val64), .wb_val(wb_val64),
        .out_valid(out_valid64), .out_ready(out_ready), .N(N64), .fwd_hit(fwd_hit64)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [65:0] sb_q[$];
    logic [65:0] sb_front;
    logic [63:0] exp_v;
    logic [1:0]  exp_h;
    int          sz;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    // Reference operand: immediates rebuilt by weighting instruction fields arithmetically.
    task automatic ref_op(input logic [2:0] s, input logic [31:0] ins, input logic [4:0] r,
                          input logic [63:0] pb, input logic [63:0] pc,
                          input logic [63:0] ev, input logic [63:0] mv, input logic [63:0] wv,
                          input int xlen, output logic [63:0] v, output logic [1:0] h);
        longint sx, imm;
        sx  = $signed(ins);
        imm = 0;
        h   = 2'd0;
        case (s)
            3'd0: begin
                if (r == 5'd0)                       imm = 0;
                else if (ex_wr  && ex_rd  == r) begin imm = ev; h = 2'd1; end
                else if (mem_wr && mem_rd == r) begin imm = mv; h = 2'd2; end
                else if (wb_wr  && wb_rd  == r) begin imm = wv; h = 2'd3; end
                else                                 imm = pb;
            end
            3'd1: imm = sx >>> 20;
            3'd2: imm = (sx >>> 25) * 32 + longint'(ins[11:7]);
            3'd3: imm = (sx >>> 12) * 4096;
            3'd4: imm = pc;
            3'd5: imm = (sx >>> 31) * 4096 + longint'(ins[7]) * 2048
                        + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
            3'd6: imm = (sx >>> 31) * 1048576 + longint'(ins[19:12]) * 4096
                        + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
            default: imm = 4;
        endcase
        v = (xlen == 32) ? {32'h0, imm[31:0]} : imm;
    endtask

    task automatic set_op(input logic [2:0] s, input logic [31:0] ins, input logic [4:0] r);
        Si = s; instr = ins; rs2 = r;
    endtask

    task automatic push_one();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        Si = 3'd7; instr = 32'h0; rs2 = 5'd0; PB = 32'h0; PC = 32'h0; PC64 = 64'h0;
        ex_wr = 1'b0; mem_wr = 1'b0; wb_wr = 1'b0;
        ex_rd = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
        ex_val = 32'h0; mem_val = 32'h0; wb_val = 32'h0;

        // Reset with in_valid asserted must leave the stage empty.
        @(posedge clk); @(posedge clk); #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_N", 64'(N), 64'd0);
        chk("rst_fwd_hit", 64'(fwd_hit), 64'd0);
        chk("rst_N64", N64, 64'd0);
        reset_n = 1'b1; in_valid = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        idle_cycle();
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        set_op(3'd1, 32'hFFF00093, 5'd0); push_one();
        chk("imm_I_valid", 64'(out_valid), 64'd1);
        chk("imm_I", 64'(N), 64'hFFFF_FFFF);
        set_op(3'd3, 32'h12345037, 5'd0); push_one();
        chk("imm_U_valid", 64'(out_valid), 64'd1);
        chk("imm_U", 64'(N), 64'h1234_5000);
        set_op(3'd5, 32'hFE000EE3, 5'd0); push_one();
        chk("imm_B_valid", 64'(out_valid), 64'd1);
        chk("imm_B", 64'(N), 64'hFFFF_FFFC);
        set_op(3'd7, 32'h0, 5'd0); push_one();
        chk("const4_valid", 64'(out_valid), 64'd1);
        chk("const4", 64'(N), 64'd4);

        PB = 32'h11;
        ex_wr = 1'b1; ex_rd = 5'd5; ex_val = 32'hAA;
        mem_wr = 1'b1; mem_rd = 5'd5; mem_val = 32'hBB;
        wb_wr = 1'b0; wb_rd = 5'd5; wb_val = 32'hCC;
        set_op(3'd0, 32'h0, 5'd5); push_one();
        chk("fwd_ex_N", 64'(N), 64'hAA);
        chk("fwd_ex_hit", 64'(fwd_hit), 64'd1);
        ex_wr = 1'b0; push_one();
        chk("fwd_mem_N", 64'(N), 64'hBB);
        chk("fwd_mem_hit", 64'(fwd_hit), 64'd2);
        mem_wr = 1'b0; wb_wr = 1'b1; push_one();
        chk("fwd_wb_N", 64'(N), 64'hCC);
        chk("fwd_wb_hit", 64'(fwd_hit), 64'd3);
        wb_wr = 1'b0; push_one();
        chk("fwd_none_N", 64'(N), 64'h11);
        chk("fwd_none_hit", 64'(fwd_hit), 64'd0);
        ex_wr = 1'b1; mem_wr = 1'b1; wb_wr = 1'b1;
        ex_rd = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
        set_op(3'd0, 32'h0, 5'd0); push_one();
        chk("x0_N", 64'(N), 64'd0);
        chk("x0_hit", 64'(fwd_hit), 64'd0);
        ex_wr = 1'b0; mem_wr = 1'b0; wb_wr = 1'b0;
        idle_cycle();
        chk("drain_out_valid", 64'(out_valid), 64'd0);

        // Backpressure: A to output, B to skid.
        out_ready = 1'b0;
        set_op(3'd1, 32'h00100013, 5'd0); push_one();
        set_op(3'd1, 32'h00200013, 5'd0); push_one();
        chk("bp_N_held", 64'(N), 64'd1);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        set_op(3'd0, 32'h0, 5'd5); PB = 32'hDEAD; idle_cycle();
        chk("bp_N_stable", 64'(N), 64'd1);
        chk("bp_valid_stable", 64'(out_valid), 64'd1);
        out_ready = 1'b1; idle_cycle();
        chk("bp_N_skid", 64'(N), 64'd2);
        chk("bp_in_ready_back", 64'(in_ready), 64'd1);
        idle_cycle();
        chk("bp_empty", 64'(out_valid), 64'd0);

        // Flush with both entries occupied and an input offered.
        out_ready = 1'b0;
        set_op(3'd1, 32'h00300013, 5'd0); push_one();
        set_op(3'd1, 32'h00500013, 5'd0); push_one();
        chk("fl_full", 64'(in_ready), 64'd0);
        set_op(3'd1, 32'h00700013, 5'd0);
        flush = 1'b1; in_valid = 1'b1;
        idle_cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        chk("fl_N_kept", 64'(N), 64'd3);
        out_ready = 1'b1;
        idle_cycle(); idle_cycle();
        chk("fl_no_ghost", 64'(out_valid), 64'd0);
        set_op(3'd1, 32'h00900013, 5'd0);
        flush = 1'b1; in_valid = 1'b1;
        idle_cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_drop_accept", 64'(out_valid), 64'd0);

        // Random traffic against a scoreboard of held operands.
        for (int i = 0; i < 130; i++) begin
            if (i < 100) begin
                in_valid  = 1'($urandom_range(0, 1));
                out_ready = ($urandom_range(0, 2) != 0);
                Si = 3'($urandom); instr = $urandom; rs2 = 5'($urandom_range(0, 7));
                PB = $urandom; PC = $urandom;
                ex_wr = 1'($urandom); mem_wr = 1'($urandom); wb_wr = 1'($urandom);
                ex_rd = 5'($urandom_range(0, 7)); mem_rd = 5'($urandom_range(0, 7));
                wb_rd = 5'($urandom_range(0, 7));
                ex_val = $urandom; mem_val = $urandom; wb_val = $urandom;
            end else begin
                in_valid = 1'b0; out_ready = 1'b1;
            end
            @(negedge clk);
            sz = sb_q.size();
            chk("rnd_out_valid", 64'(out_valid), 64'(sz > 0));
            chk("rnd_in_ready", 64'(in_ready), 64'(sz < 2));
            if (out_ready && sz > 0) begin
                sb_front = sb_q.pop_front();
                chk("rnd_N", 64'(N), {32'h0, sb_front[31:0]});
                chk("rnd_hit", 64'(fwd_hit), 64'(sb_front[65:64]));
            end
            if (in_valid && sz < 2) begin
                ref_op(Si, instr, rs2, {32'h0, PB}, {32'h0, PC}, {32'h0, ex_val},
                       {32'h0, mem_val}, {32'h0, wb_val}, 32, exp_v, exp_h);
                sb_q.push_back({exp_h, exp_v});
            end
            @(posedge clk); #1;
        end

        ex_wr = 1'b0; mem_wr = 1'b0; wb_wr = 1'b0; out_ready = 1'b1;
        set_op(3'd1, 32'h80000013, 5'd0); push_one();
        chk("x64_valid", 64'(out_valid64), 64'd1);
        chk("x64_imm_I", N64, 64'hFFFF_FFFF_FFFF_F800);
        PC64 = 64'h0000_0001_0000_0000;
        set_op(3'd4, 32'h0, 5'd0); push_one();
        chk("x64_PC", N64, 64'h0000_0001_0000_0000);
        set_op(3'd6, 32'h8000_006F, 5'd0); push_one();
        ref_op(3'd6, 32'h8000_006F, 5'd0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64, exp_v, exp_h);
        chk("x64_imm_J", N64, exp_v);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
